// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with flush, bubble/flush counters and illegal-stall flag
module pipe_stage_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter int               STALL_W = 6,
    parameter int               STAGE   = 2,
    parameter int               CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               stall_err
);
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
    end
    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_width
        $error("pipe_stage_reg: WIDTH and CNT_W must be at least 1");
    end
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   bub_q, bub_d, fl_q, fl_d;
    logic               err_q, err_d;
    logic               up, dn, bubble, illegal, advance, unused_stall;
    assign unused_stall = ^stall;
    // Decode the stall pair into one slot action; flush takes precedence over every stall pattern
    always_comb begin
        up      = stall[STAGE];
        dn      = stall[STAGE+1];
        bubble  = !flush && up && !dn;
        illegal = !flush && !up && dn;
        advance = !flush && !up && !dn;
        valid_d = (flush || bubble) ? 1'b0 : advance ? in_valid : valid_q;
        data_d  = (flush || bubble || (advance && !in_valid)) ? NOP_VAL : advance ? in_data : data_q;
        err_d   = err_q || illegal;
        bub_d   = cnt_clr ? '0 : (bubble && bub_q != '1) ? bub_q + 1'b1 : bub_q;
        fl_d    = cnt_clr ? '0 : (flush && fl_q != '1) ? fl_q + 1'b1 : fl_q;
    end
    // Slot, counters and sticky error register; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VAL;
            bub_q   <= '0;
            fl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bub_q   <= bub_d;
            fl_q    <= fl_d;
            err_q   <= err_d;
        end
    end
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign bubble_cnt = bub_q;
    assign flush_cnt  = fl_q;
    assign stall_err  = err_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       stall = '0;
    logic             flush = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;
    logic             stall_err;
    int checks = 0;
    int errors = 0;
    bit        m_valid, m_err;
    bit [31:0] m_data;
    int        m_bub, m_fl;

    pipe_stage_reg #(.WIDTH(WIDTH), .NOP_VAL('0), .STALL_W(6), .STAGE(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: apply the rule table to the inputs seen at this edge
    task automatic model_update();
        string act;
        if (rst) begin
            m_valid = 0; m_data = 0; m_bub = 0; m_fl = 0; m_err = 0;
            return;
        end
        if (flush)                      act = "flush";
        else if (stall[2] && !stall[3]) act = "bubble";
        else if (!stall[2] && stall[3]) act = "illegal";
        else if (!stall[2])             act = "advance";
        else                            act = "hold";
        if (act == "flush" || act == "bubble") begin
            m_valid = 0; m_data = 0;
        end
        if (act == "advance") begin
            m_valid = in_valid; m_data = in_valid ? in_data : 0;
        end
        if (act == "illegal") m_err = 1;
        if (act == "flush")  m_fl  = (m_fl + 1 > CMAX) ? CMAX : m_fl + 1;
        if (act == "bubble") m_bub = (m_bub + 1 > CMAX) ? CMAX : m_bub + 1;
        if (cnt_clr) begin
            m_bub = 0; m_fl = 0;
        end
    endtask

    task automatic compare_model();
        check("model_valid", 32'(out_valid), 32'(m_valid));
        check("model_data",  out_data, m_data);
        check("model_bub",   32'(bubble_cnt), 32'(m_bub));
        check("model_fl",    32'(flush_cnt), 32'(m_fl));
        check("model_err",   32'(stall_err), 32'(m_err));
    endtask

    task automatic step(input bit r, input bit [5:0] s, input bit f, input bit c, input bit v, input bit [31:0] d);
        rst = r; stall = s; flush = f; cnt_clr = c; in_valid = v; in_data = d;
        @(posedge clk);
        model_update();
        #1;
        compare_model();
    endtask

    initial begin
        // T1 reset then advance
        step(1, 6'b0, 0, 0, 1, 32'hDEAD_BEEF);
        step(1, 6'b0, 0, 0, 1, 32'hDEAD_BEEF);
        check("t1_rst_valid", 32'(out_valid), 32'd0);
        check("t1_rst_data", out_data, 32'd0);
        step(0, 6'b0, 0, 0, 1, 32'hDEAD_BEEF);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", out_data, 32'hDEAD_BEEF);
        // T2 bubble
        step(0, 6'b000100, 0, 0, 1, 32'h1234);
        check("t2_valid", 32'(out_valid), 32'd0);
        check("t2_data", out_data, 32'd0);
        check("t2_bub", 32'(bubble_cnt), 32'd1);
        step(0, 6'b0, 0, 0, 1, 32'h1234);
        check("t2_adv_data", out_data, 32'h1234);
        // T3 hold
        for (int i = 0; i < 3; i++) step(0, 6'b001100, 0, 0, 1, 32'hA000 + 32'(i));
        check("t3_data", out_data, 32'h1234);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_bub", 32'(bubble_cnt), 32'd1);
        // T4 flush over hold
        step(0, 6'b001100, 1, 0, 1, 32'h5555);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_fl", 32'(flush_cnt), 32'd1);
        check("t4_bub", 32'(bubble_cnt), 32'd1);
        // T5 illegal pattern, slot held, error sticky
        step(0, 6'b0, 0, 0, 1, 32'h77);
        step(0, 6'b001000, 0, 0, 1, 32'h88);
        check("t5_hold", out_data, 32'h77);
        check("t5_err", 32'(stall_err), 32'd1);
        step(0, 6'b0, 0, 0, 1, 32'h99);
        check("t5_sticky", 32'(stall_err), 32'd1);
        step(0, 6'b001000, 1, 0, 0, 32'h0);
        step(1, 6'b0, 0, 0, 0, 32'h0);
        check("t5_rst_clr", 32'(stall_err), 32'd0);
        step(0, 6'b001000, 1, 0, 0, 32'h0);
        check("t5_flush_no_err", 32'(stall_err), 32'd0);
        // T6 saturation and clear priority
        for (int i = 0; i < 5; i++) step(0, 6'b110100, 0, 0, 1, 32'(i));
        check("t6_sat", 32'(bubble_cnt), 32'd3);
        for (int i = 0; i < 4; i++) step(0, 6'b0, 1, 0, 1, 32'(i));
        check("t6_fl_sat", 32'(flush_cnt), 32'd3);
        step(0, 6'b000100, 0, 1, 1, 32'h1);
        check("t6_clr_bub", 32'(bubble_cnt), 32'd0);
        check("t6_clr_fl", 32'(flush_cnt), 32'd0);
        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, 6'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 19) == 0, 1'($urandom), $urandom);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
